// File: rtl/parity_err_monitor.sv
// Collects active-low parity status lines into sticky flags, a mismatch counter and a fault FSM.
// Optional PARITY_MON_INPUT_SYNC_EN adds a 2-flop input synchronizer.
module parity_err_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int THRESH = 3,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] parity_ok_i,
    input  logic [NUM_CH-1:0] mask_i,
    input  logic              clear_i,
    output logic [NUM_CH-1:0] err_sticky_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [IDX_W-1:0]  first_ch_o,
    output logic              first_vld_o,
    output logic              fault_irq_o
);

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_PEND  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    logic [NUM_CH-1:0] ok_d;
    logic [NUM_CH-1:0] ok_q;
    logic [NUM_CH-1:0] mm;
    logic              any_mm;
    logic [IDX_W-1:0]  low_idx;

    logic [NUM_CH-1:0] sticky_q;
    logic [NUM_CH-1:0] sticky_base;
    logic [NUM_CH-1:0] sticky_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDX_W-1:0]  first_q;
    logic [IDX_W-1:0]  first_d;
    logic              vld_q;
    logic              vld_base;
    logic              vld_d;
    logic              irq_q;
    state_t            state_q;
    state_t            state_base;
    state_t            state_d;

`ifdef PARITY_MON_INPUT_SYNC_EN
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= parity_ok_i;
            sync2 <= sync1;
        end
    end

    assign ok_d = sync2;
`else
    assign ok_d = parity_ok_i;
`endif

    // Reset to all-ones so the first cycle out of reset never looks like an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            ok_q <= '1;
        end else begin
            ok_q <= ok_d;
        end
    end

    assign mm     = ~ok_q & ~mask_i;
    assign any_mm = |mm;

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mm[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // A clear wipes history first; an error in the same cycle is then applied on top.
    always_comb begin
        sticky_base = clear_i ? '0 : sticky_q;
        cnt_base    = clear_i ? '0 : cnt_q;
        vld_base    = clear_i ? 1'b0 : vld_q;
        state_base  = clear_i ? ST_OK : state_q;
    end

    always_comb begin
        sticky_d = sticky_base | mm;
        vld_d    = vld_base | any_mm;
        cnt_d    = cnt_base;
        if (any_mm && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + 1'b1;
        end
        first_d = clear_i ? '0 : first_q;
        if (any_mm && !vld_base) begin
            first_d = low_idx;
        end
    end

    always_comb begin
        state_d = state_base;
        unique case (state_base)
            ST_OK: begin
                if (any_mm) begin
                    state_d = (cnt_d >= THR) ? ST_FAULT : ST_PEND;
                end
            end
            ST_PEND: begin
                if (any_mm && (cnt_d >= THR)) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_OK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OK;
            sticky_q <= '0;
            cnt_q    <= '0;
            first_q  <= '0;
            vld_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            vld_q    <= vld_d;
            irq_q    <= (state_d == ST_FAULT);
        end
    end

    assign err_sticky_o = sticky_q;
    assign err_cnt_o    = cnt_q;
    assign first_ch_o   = first_q;
    assign first_vld_o  = vld_q;
    assign fault_irq_o  = irq_q;

endmodule

// File: tb/tb_parity_err_monitor.sv
// Directed bench for parity_err_monitor: default instance (8-bit count, THRESH=3)
// and a second instance with CNT_W=2, THRESH=1 for saturation.
module tb_parity_err_monitor;

`ifdef PARITY_MON_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ok;
    logic [3:0] mask;
    logic       clear;

    logic [3:0] a_sticky;
    logic [7:0] a_cnt;
    logic [1:0] a_first;
    logic       a_vld;
    logic       a_irq;
    logic [3:0] b_sticky;
    logic [1:0] b_cnt;
    logic [1:0] b_first;
    logic       b_vld;
    logic       b_irq;

    logic [15:0] a_obs;
    logic [9:0]  b_obs;
    assign a_obs = {a_sticky, a_cnt, a_first, a_vld, a_irq};
    assign b_obs = {b_sticky, b_cnt, b_first, b_vld, b_irq};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_err_monitor #(.NUM_CH(4), .CNT_W(8), .THRESH(3)) dut_a (
        .clk(clk), .rst(rst), .parity_ok_i(ok), .mask_i(mask),
        .clear_i(clear), .err_sticky_o(a_sticky), .err_cnt_o(a_cnt),
        .first_ch_o(a_first), .first_vld_o(a_vld), .fault_irq_o(a_irq)
    );

    parity_err_monitor #(.NUM_CH(4), .CNT_W(2), .THRESH(1)) dut_b (
        .clk(clk), .rst(rst), .parity_ok_i(ok), .mask_i(mask),
        .clear_i(clear), .err_sticky_o(b_sticky), .err_cnt_o(b_cnt),
        .first_ch_o(b_first), .first_vld_o(b_vld), .fault_irq_o(b_irq)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ok = 4'hF; mask = 4'h0; clear = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        n_checks++;
        if (a_obs !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected %h", a_obs, 16'h0);
        end
        n_checks++;
        if (b_obs !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected %h", b_obs, 10'h0);
        end
    endtask

    task automatic test_single_err;
        ok = 4'hB; cyc(1); ok = 4'hF; cyc(LAT);
        n_checks++;
        if (a_obs !== {4'h4, 8'd1, 2'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_err: got %h expected %h", a_obs,
                     {4'h4, 8'd1, 2'd2, 1'b1, 1'b0});
        end
    endtask

    task automatic test_threshold;
        ok = 4'hE; cyc(1); ok = 4'hF; cyc(LAT);
        n_checks++;
        if (a_obs !== {4'h5, 8'd2, 2'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL thresh_2nd: got %h expected %h", a_obs,
                     {4'h5, 8'd2, 2'd2, 1'b1, 1'b0});
        end
        ok = 4'hE; cyc(1); ok = 4'hF;
        if (LAT > 1) cyc(LAT - 1);
        n_checks++;
        if (a_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL thresh_pre_irq: got %b expected 0", a_irq);
        end
        cyc(1);
        n_checks++;
        if (a_obs !== {4'h5, 8'd3, 2'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL thresh_fault: got %h expected %h", a_obs,
                     {4'h5, 8'd3, 2'd2, 1'b1, 1'b1});
        end
        cyc(5);
        n_checks++;
        if (a_obs !== {4'h5, 8'd3, 2'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL thresh_hold: got %h expected %h", a_obs,
                     {4'h5, 8'd3, 2'd2, 1'b1, 1'b1});
        end
    endtask

    task automatic test_clear;
        ok = 4'hD; cyc(1); ok = 4'hF;
        if (LAT > 1) cyc(LAT - 1);
        clear = 1'b1; cyc(1); clear = 1'b0;
        n_checks++;
        if (a_obs !== {4'h2, 8'd1, 2'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_with_err: got %h expected %h", a_obs,
                     {4'h2, 8'd1, 2'd1, 1'b1, 1'b0});
        end
        ok = 4'hD; cyc(1); ok = 4'hF; cyc(LAT);
        ok = 4'hD; cyc(1); ok = 4'hF; cyc(LAT);
        n_checks++;
        if (a_obs !== {4'h2, 8'd3, 2'd1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL clear_refault: got %h expected %h", a_obs,
                     {4'h2, 8'd3, 2'd1, 1'b1, 1'b1});
        end
        clear = 1'b1; cyc(1); clear = 1'b0;
        n_checks++;
        if (a_obs !== 16'h0) begin
            n_fail++;
            $display("FAIL clear_plain: got %h expected %h", a_obs, 16'h0);
        end
        ok = 4'hE; cyc(1); ok = 4'hF; cyc(LAT);
        n_checks++;
        if (a_obs !== {4'h1, 8'd1, 2'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_reload: got %h expected %h", a_obs,
                     {4'h1, 8'd1, 2'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_saturate;
        rst = 1'b1; cyc(1); rst = 1'b0;
        n_checks++;
        if (b_obs !== 10'h0) begin
            n_fail++;
            $display("FAIL sat_reset: got %h expected %h", b_obs, 10'h0);
        end
        ok = 4'hE; cyc(LAT + 1);
        n_checks++;
        if (b_obs !== {4'h1, 2'd1, 2'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_first: got %h expected %h", b_obs,
                     {4'h1, 2'd1, 2'd0, 1'b1, 1'b1});
        end
        cyc(5 - LAT); ok = 4'hF; cyc(LAT);
        n_checks++;
        if (b_obs !== {4'h1, 2'd3, 2'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_b: got %h expected %h", b_obs,
                     {4'h1, 2'd3, 2'd0, 1'b1, 1'b1});
        end
        n_checks++;
        if (a_obs !== {4'h1, 8'd6, 2'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_a_count: got %h expected %h", a_obs,
                     {4'h1, 8'd6, 2'd0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_mask_rst;
        rst = 1'b1; cyc(1); rst = 1'b0;
        ok = 4'hB; cyc(1); ok = 4'hF; cyc(LAT);
        mask = 4'h8; ok = 4'h7; cyc(4); ok = 4'hF; cyc(LAT);
        n_checks++;
        if (a_obs !== {4'h4, 8'd1, 2'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mask_ch3: got %h expected %h", a_obs,
                     {4'h4, 8'd1, 2'd2, 1'b1, 1'b0});
        end
        mask = 4'h4; ok = 4'hB; cyc(1); ok = 4'hF; cyc(LAT);
        n_checks++;
        if (a_obs !== {4'h4, 8'd1, 2'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mask_keep_sticky: got %h expected %h", a_obs,
                     {4'h4, 8'd1, 2'd2, 1'b1, 1'b0});
        end
        mask = 4'h0; ok = 4'hE; rst = 1'b1; cyc(1);
        n_checks++;
        if (a_obs !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid_pend: got %h expected %h", a_obs, 16'h0);
        end
        rst = 1'b0; ok = 4'hF; cyc(LAT + 1);
        n_checks++;
        if (a_obs !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_settle: got %h expected %h", a_obs, 16'h0);
        end
    endtask

    task automatic test_multi_channel;
        ok = 4'h5; cyc(1); ok = 4'hF; cyc(LAT);
        n_checks++;
        if (a_obs !== {4'hA, 8'd1, 2'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL multi_ch: got %h expected %h", a_obs,
                     {4'hA, 8'd1, 2'd1, 1'b1, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_single_err();
        test_threshold();
        test_clear();
        test_saturate();
        test_mask_rst();
        test_multi_channel();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
